// File: rtl/rgen_pkg.sv
// Shared types for the register-block command/response protocol.
package rgen_pkg;

  // Response status returned to the host.
  typedef enum logic [1:0] {
    RGEN_STATUS_OKAY         = 2'b00,
    RGEN_STATUS_SLAVE_ERROR  = 2'b01,
    RGEN_STATUS_EXOKAY       = 2'b10,
    RGEN_STATUS_TIMEOUT      = 2'b11
  } rgen_status_t;

  // Command initiator sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StCommand,
    StResponse
  } initiator_state_t;

endpackage

// File: rtl/rgen_command_initiator.sv
// Host-side initiator: accepts one host request, issues one command to the register
// block, waits for its one-cycle response pulse and returns data/status to the host.
// Optional: define RGEN_INITIATOR_TIMEOUT_EN to force a timeout response after
// TIMEOUT_CYCLES cycles in the command state.
module rgen_command_initiator
  import rgen_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_read,
  input  logic [ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [DATA_WIDTH-1:0]    i_req_write_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_WIDTH-1:0]    o_rsp_read_data,
  output logic [1:0]               o_rsp_status,
  output logic                     o_command_valid,
  output logic                     o_command_read,
  output logic [ADDRESS_WIDTH-1:0] o_command_address,
  output logic [DATA_WIDTH-1:0]    o_command_write_data,
  input  logic                     i_response_ready,
  input  logic [DATA_WIDTH-1:0]    i_read_data,
  input  logic [1:0]               i_status
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  initiator_state_t state_q;

`ifdef RGEN_INITIATOR_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);
  logic [CntWidth-1:0] cnt_q;
`endif

  // Sequencer with all host and command outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= StIdle;
      o_req_ready          <= 1'b1;
      o_rsp_valid          <= 1'b0;
      o_rsp_read_data      <= '0;
      o_rsp_status         <= RGEN_STATUS_OKAY;
      o_command_valid      <= 1'b0;
      o_command_read       <= 1'b0;
      o_command_address    <= '0;
      o_command_write_data <= '0;
`ifdef RGEN_INITIATOR_TIMEOUT_EN
      cnt_q                <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (i_req_valid) begin
            state_q              <= StCommand;
            o_req_ready          <= 1'b0;
            o_command_valid      <= 1'b1;
            o_command_read       <= i_req_read;
            o_command_address    <= i_req_address;
            o_command_write_data <= i_req_write_data;
`ifdef RGEN_INITIATOR_TIMEOUT_EN
            cnt_q                <= '0;
`endif
          end
        end
        StCommand: begin
          // A real response takes priority over a coincident timeout expiry.
          if (i_response_ready) begin
            state_q         <= StResponse;
            o_command_valid <= 1'b0;
            o_command_read  <= 1'b0;
            o_rsp_valid     <= 1'b1;
            o_rsp_status    <= i_status;
            o_rsp_read_data <= o_command_read ? i_read_data : '0;
          end
`ifdef RGEN_INITIATOR_TIMEOUT_EN
          else if (cnt_q == CntLast) begin
            state_q         <= StResponse;
            o_command_valid <= 1'b0;
            o_command_read  <= 1'b0;
            o_rsp_valid     <= 1'b1;
            o_rsp_status    <= RGEN_STATUS_TIMEOUT;
            o_rsp_read_data <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StResponse: begin
          if (i_rsp_ready) begin
            state_q         <= StIdle;
            o_req_ready     <= 1'b1;
            o_rsp_valid     <= 1'b0;
            o_rsp_read_data <= '0;
            o_rsp_status    <= RGEN_STATUS_OKAY;
          end
        end
        default: begin
          state_q     <= StIdle;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgen_command_initiator.sv
// Self-checking bench for rgen_command_initiator: transaction-level reference model,
// per-cycle output comparison, directed scenarios and randomized traffic.
module tb_rgen_command_initiator;

  localparam int TMO = 4;
`ifdef RGEN_INITIATOR_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_read = 1'b0;
  logic [15:0] i_req_address = '0;
  logic [31:0] i_req_write_data = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_read_data;
  logic [1:0]  o_rsp_status;
  logic        o_command_valid;
  logic        o_command_read;
  logic [15:0] o_command_address;
  logic [31:0] o_command_write_data;
  logic        i_response_ready = 1'b0;
  logic [31:0] i_read_data = '0;
  logic [1:0]  i_status = '0;

  int compared = 0;
  int mismatched = 0;

  rgen_command_initiator #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_req_valid         (i_req_valid),
    .o_req_ready         (o_req_ready),
    .i_req_read          (i_req_read),
    .i_req_address       (i_req_address),
    .i_req_write_data    (i_req_write_data),
    .o_rsp_valid         (o_rsp_valid),
    .i_rsp_ready         (i_rsp_ready),
    .o_rsp_read_data     (o_rsp_read_data),
    .o_rsp_status        (o_rsp_status),
    .o_command_valid     (o_command_valid),
    .o_command_read      (o_command_read),
    .o_command_address   (o_command_address),
    .o_command_write_data(o_command_write_data),
    .i_response_ready    (i_response_ready),
    .i_read_data         (i_read_data),
    .i_status            (i_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction described by its phase
  // (0 = waiting for a host request, 1 = command outstanding, 2 = response held).
  int          m_phase = 0;
  int          m_wait = 0;
  bit          m_read = 1'b0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_status = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_wait = 0; m_read = 1'b0; m_addr = '0; m_wdata = '0;
      m_rdata = '0; m_status = '0;
    end else if (m_phase == 0) begin
      if (i_req_valid) begin
        m_phase = 1; m_wait = 0; m_read = i_req_read;
        m_addr = i_req_address; m_wdata = i_req_write_data;
      end
    end else if (m_phase == 1) begin
      if (i_response_ready) begin
        m_phase = 2; m_status = i_status; m_rdata = m_read ? i_read_data : 32'h0;
      end else if (TIMEOUT_ON && (m_wait + 1 == TMO)) begin
        m_phase = 2; m_status = 2'b11; m_rdata = 32'h0;
      end else begin
        m_wait++;
      end
    end else begin
      if (i_rsp_ready) begin
        m_phase = 0; m_rdata = '0; m_status = '0;
      end
    end
  end

  // Every cycle, compare all outputs against the model on the falling edge.
  always @(negedge clk) begin
    chk("req_ready", 64'(o_req_ready), 64'(m_phase == 0));
    chk("command_valid", 64'(o_command_valid), 64'(m_phase == 1));
    chk("command_read", 64'(o_command_read), 64'((m_phase == 1) && m_read));
    chk("command_address", 64'(o_command_address), 64'(m_addr));
    chk("command_write_data", 64'(o_command_write_data), 64'(m_wdata));
    chk("rsp_valid", 64'(o_rsp_valid), 64'(m_phase == 2));
    chk("rsp_read_data", 64'(o_rsp_read_data), 64'(m_rdata));
    chk("rsp_status", 64'(o_rsp_status), 64'(m_status));
  end

  // One transaction; call at posedge+1. d is the command cycle index carrying the
  // response pulse (-1: never). Returns command cycle count and the held response.
  task automatic txn(input bit rd, input logic [15:0] a, input logic [31:0] wd,
                     input int d, input logic [31:0] rdat, input logic [1:0] st,
                     input int stall, input bit stray, output int ncmd,
                     output logic [31:0] got_data, output logic [1:0] got_st);
    bit done;
    ncmd = 0;
    done = 1'b0;
    chk("txn_start_ready", 64'(o_req_ready), 64'd1);
    i_req_valid = 1'b1; i_req_read = rd; i_req_address = a; i_req_write_data = wd;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!o_command_valid) begin
        done = 1'b1;
        break;
      end
      ncmd++;
      chk("txn_cmd_read", 64'(o_command_read), 64'(rd));
      if (i == d) begin
        i_response_ready = 1'b1; i_read_data = rdat; i_status = st;
      end
      @(posedge clk); #1;
      i_response_ready = 1'b0;
    end
    if (!done) chk("txn_cmd_bound", 64'd1, 64'd0);
    chk("txn_rsp_valid", 64'(o_rsp_valid), 64'd1);
    got_data = o_rsp_read_data;
    got_st = o_rsp_status;
    for (int s = 0; s < stall; s++) begin
      chk("stall_req_ready", 64'(o_req_ready), 64'd0);
      chk("stall_rsp_valid", 64'(o_rsp_valid), 64'd1);
      chk("stall_rsp_data", 64'(o_rsp_read_data), 64'(got_data));
      chk("stall_rsp_status", 64'(o_rsp_status), 64'(got_st));
      if (stray && s == 1) begin
        i_response_ready = 1'b1; i_read_data = 32'hA5A5_5A5A; i_status = ~st;
      end
      @(posedge clk); #1;
      i_response_ready = 1'b0;
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    chk("post_rsp_req_ready", 64'(o_req_ready), 64'd1);
    chk("post_rsp_valid", 64'(o_rsp_valid), 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] rdv;
    logic [1:0]  stv;

    // Reset values.
    #12;
    chk("reset_req_ready", 64'(o_req_ready), 64'd1);
    chk("reset_command_valid", 64'(o_command_valid), 64'd0);
    chk("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("reset_command_address", 64'(o_command_address), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Stray pulse while idle.
    i_response_ready = 1'b1; i_status = 2'b01; i_read_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    i_response_ready = 1'b0;
    chk("stray_idle_req_ready", 64'(o_req_ready), 64'd1);
    chk("stray_idle_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("stray_idle_cmd_valid", 64'(o_command_valid), 64'd0);

    // Write, pulse in the second command cycle.
    txn(1'b0, 16'h0010, 32'hDEAD_BEEF, 1, 32'h1111_2222, 2'b00, 0, 1'b0, n, rdv, stv);
    chk("write_cmd_cycles", 64'(n), 64'd2);
    chk("write_rsp_data", 64'(rdv), 64'd0);
    chk("write_rsp_status", 64'(stv), 64'd0);
    chk("write_cmd_addr", 64'(o_command_address), 64'h0010);
    chk("write_cmd_wdata", 64'(o_command_write_data), 64'hDEAD_BEEF);

    // Read, pulse in the first command cycle.
    txn(1'b1, 16'h0004, 32'h0, 0, 32'h1234_5678, 2'b00, 0, 1'b0, n, rdv, stv);
    chk("read_cmd_cycles", 64'(n), 64'd1);
    chk("read_rsp_data", 64'(rdv), 64'h1234_5678);
    chk("read_rsp_status", 64'(stv), 64'd0);

    // Slave error with 5-cycle host stall and a stray pulse in the response state,
    // then a back-to-back request.
    txn(1'b1, 16'h0020, 32'h0, 0, 32'hCAFE_F00D, 2'b01, 5, 1'b1, n, rdv, stv);
    chk("slverr_rsp_status", 64'(stv), 64'd1);
    chk("slverr_rsp_data", 64'(rdv), 64'hCAFE_F00D);
    txn(1'b0, 16'h0030, 32'h0BAD_CAFE, 2, 32'h0, 2'b10, 1, 1'b0, n, rdv, stv);
    chk("b2b_cmd_cycles", 64'(n), 64'd3);
    chk("b2b_rsp_status", 64'(stv), 64'd2);

    if (TIMEOUT_ON) begin
      txn(1'b1, 16'h0040, 32'h0, -1, 32'h0, 2'b00, 0, 1'b0, n, rdv, stv);
      chk("timeout_cmd_cycles", 64'(n), 64'd4);
      chk("timeout_rsp_status", 64'(stv), 64'd3);
      chk("timeout_rsp_data", 64'(rdv), 64'd0);
      txn(1'b1, 16'h0044, 32'h0, 3, 32'h7777_0001, 2'b01, 0, 1'b0, n, rdv, stv);
      chk("expiry_race_cycles", 64'(n), 64'd4);
      chk("expiry_race_status", 64'(stv), 64'd1);
      chk("expiry_race_data", 64'(rdv), 64'h7777_0001);
    end

    // Reset in the middle of a command.
    i_req_valid = 1'b1; i_req_read = 1'b1; i_req_address = 16'h0050;
    i_req_write_data = 32'h5555_AAAA;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    chk("midcmd_cmd_valid", 64'(o_command_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cmd_valid", 64'(o_command_valid), 64'd0);
    chk("rst_cmd_read", 64'(o_command_read), 64'd0);
    chk("rst_req_ready", 64'(o_req_ready), 64'd1);
    chk("rst_cmd_addr", 64'(o_command_address), 64'd0);
    chk("rst_cmd_wdata", 64'(o_command_write_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_response_ready = 1'b1; i_status = 2'b01; i_read_data = 32'h0000_BEEF;
    @(posedge clk); #1;
    i_response_ready = 1'b0;
    chk("late_pulse_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("late_pulse_req_ready", 64'(o_req_ready), 64'd1);

    // Randomized traffic, checked every cycle by the model comparison.
    for (int c = 0; c < 3000; c++) begin
      i_req_valid      = ($urandom_range(0, 1) == 1);
      i_req_read       = ($urandom_range(0, 1) == 1);
      i_req_address    = 16'($urandom);
      i_req_write_data = $urandom;
      i_response_ready = ($urandom_range(0, 3) == 0);
      i_read_data      = $urandom;
      i_status         = 2'($urandom_range(0, 3));
      i_rsp_ready      = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    i_req_valid = 1'b0; i_response_ready = 1'b0; i_rsp_ready = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rgen_command_initiator.md
Name: rgen_command_initiator

Overview:
Host-side initiator for the register-block command/response protocol. It accepts one host request at a time over a valid/ready channel and drives one command to the register block. It then waits for the register block's single-cycle response pulse and returns read data and status on a valid/ready response channel. It sits between a bus bridge (APB/AXI-lite front end) and the register block.

Parameters:
ADDRESS_WIDTH, 16, width of command address.
DATA_WIDTH, 32, width of read/write data.
TIMEOUT_CYCLES, 255, cycles in COMMAND before forced timeout response; used only with RGEN_INITIATOR_TIMEOUT_EN; legal range >= 2.

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
i_req_valid  input  1  host request valid
o_req_ready  output  1  request accepted when valid&&ready
i_req_read  input  1  1=read, 0=write
i_req_address  input  ADDRESS_WIDTH  request address
i_req_write_data  input  DATA_WIDTH  write data
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  host accepts response
o_rsp_read_data  output  DATA_WIDTH  read data; 0 for writes
o_rsp_status  output  2  response status (rgen_status_t)
o_command_valid  output  1  command to register block
o_command_read  output  1  command is read
o_command_address  output  ADDRESS_WIDTH  command address
o_command_write_data  output  DATA_WIDTH  command write data
i_response_ready  input  1  one-cycle response pulse from register block
i_read_data  input  DATA_WIDTH  register block read data, valid with i_response_ready
i_status  input  2  register block status, valid with i_response_ready

Behaviour:
- FSM states: IDLE, COMMAND, RESPONSE. All outputs are registered or decoded directly from state.
- Reset: state=IDLE. o_req_ready=1, o_rsp_valid=0, o_command_valid=0, o_command_read=0. Address, write data, o_rsp_read_data and o_rsp_status are all 0.
- o_req_ready=1 only in IDLE; no request queuing.
- IDLE -> COMMAND on i_req_valid&&o_req_ready. At that edge, latch read/address/write_data into the command outputs and set o_command_valid=1.
- COMMAND: command outputs are held stable. On the edge where i_response_ready=1:
  - clear o_command_valid (it is high in the pulse cycle and low in the next cycle, so the register block issues exactly one response);
  - capture o_rsp_status=i_status;
  - capture o_rsp_read_data=i_read_data if read, else 0;
  - set o_rsp_valid=1; go to RESPONSE.
- RESPONSE: outputs held until i_rsp_ready. On that edge: o_rsp_valid=0, read data and status cleared to 0, go to IDLE. A new request is accepted no earlier than the following cycle.
- Nominal latency: request accept edge T0; response pulse in cycle T1; o_rsp_valid high from T2 (2 cycles).
- i_response_ready outside COMMAND is ignored: no state change, no capture.
- o_command_address and o_command_write_data keep their last value after a command completes. o_command_read is cleared with o_command_valid.
- Asynchronous reset mid-operation: immediate return to reset values. Any in-flight response is discarded.

Optional Feature:
RGEN_INITIATOR_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to COMMAND and increments each COMMAND cycle without i_response_ready.
  - When the count reaches TIMEOUT_CYCLES-1 and i_response_ready=0: clear o_command_valid, set o_rsp_status=RGEN_STATUS_TIMEOUT (2'b11), set o_rsp_read_data=0, go to RESPONSE.
  - If i_response_ready=1 in the same cycle as expiry, the real response wins.
- Not defined: no counter; COMMAND waits indefinitely.

Decomposition:
- Shared package rgen_pkg:
  - rgen_status_t enum, 2 bits: RGEN_STATUS_OKAY=2'b00, RGEN_STATUS_SLAVE_ERROR=2'b01, RGEN_STATUS_EXOKAY=2'b10, RGEN_STATUS_TIMEOUT=2'b11.
  - initiator state enum.
- No sub-module; the timeout counter stays inline under the macro.

Test Plan:
- Write: req addr=0x0010, data=0xDEADBEEF, read=0; response pulse 1 cycle after command -> exactly 1 command_valid pulse of 2 cycles; rsp_valid at T2 with status=00, read_data=0.
- Read: addr=0x0004, i_read_data=0x12345678 with pulse -> rsp read_data=0x12345678, status=00; command_read=1 throughout COMMAND.
- Slave error + host stall: i_status=2'b01, hold i_rsp_ready=0 for 5 cycles -> rsp_valid/data/status stable 5 cycles, o_req_ready=0; second req accepted the cycle after rsp handshake.
- Stray pulse: i_response_ready=1 while IDLE and while RESPONSE -> no state or output change.
- Timeout (macro on, TIMEOUT_CYCLES=4): no response -> command_valid drops after 4 COMMAND cycles, rsp status=2'b11, data=0; a repeat run with the pulse on the expiry cycle -> status=i_status.
- Reset mid-COMMAND: assert rst_n=0 while command_valid=1 -> all outputs at reset values immediately; a late response pulse after release is ignored.
